// File: rtl/rv32_pkg.sv
// rtl/rv32_pkg.sv - shared pipeline widths, NOP constant and fetch packet type
package rv32_pkg;

    localparam int XLEN = 32;
    localparam int ILEN = 32;

    // addi x0, x0, 0 -- decode substitutes this while the queue is empty
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [ILEN-1:0] instr;
    } fetch_pkt_t;

endpackage

// File: rtl/fetch_queue_if.sv
// rtl/fetch_queue_if.sv - enqueue/dequeue handshake bundle between fetch, queue and decode
interface fetch_queue_if #(
    parameter int XLEN = rv32_pkg::XLEN,
    parameter int ILEN = rv32_pkg::ILEN
);
    logic            enq_valid;
    logic [XLEN-1:0] enq_pc;
    logic [ILEN-1:0] enq_instr;
    logic            enq_ready;
    logic            deq_valid;
    logic [XLEN-1:0] deq_pc;
    logic [ILEN-1:0] deq_instr;
    logic            deq_ready;

    // master: fetch (producer) plus decode (consumer); slave: the queue itself
    modport master (
        output enq_valid, enq_pc, enq_instr, deq_ready,
        input  enq_ready, deq_valid, deq_pc, deq_instr
    );

    modport slave (
        input  enq_valid, enq_pc, enq_instr, deq_ready,
        output enq_ready, deq_valid, deq_pc, deq_instr
    );
endinterface

// File: rtl/fetch_queue_storage.sv
// rtl/fetch_queue_storage.sv - register array, synchronous write, asynchronous read
module fetch_queue_storage #(
    parameter  int DEPTH = 4,
    parameter  int WIDTH = rv32_pkg::XLEN + rv32_pkg::ILEN,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             we_i,
    input  logic [AW-1:0]    waddr_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic [AW-1:0]    raddr_i,
    output logic [WIDTH-1:0] rdata_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/fetch_queue.sv
// rtl/fetch_queue.sv - IF/ID instruction FIFO with flush and occupancy high-water mark
module fetch_queue #(
    parameter  int DEPTH = 4,
    parameter  int XLEN  = rv32_pkg::XLEN,
    parameter  int ILEN  = rv32_pkg::ILEN,
    localparam int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    fetch_queue_if.slave     bus,
    output logic [CNT_W-1:0] count,
    output logic [CNT_W-1:0] max_count
);

    localparam int               PTR_W    = $clog2(DEPTH);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    logic [PTR_W-1:0]     rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0]     count_q, count_d;
    logic [CNT_W-1:0]     max_q, max_d;
    logic                 enq_ready_w, deq_valid_w;
    logic                 enq_fire, deq_fire;
    logic [XLEN+ILEN-1:0] rd_data;

    // Status depends only on registered count, keeping deq_ready off the enq_ready path
    assign enq_ready_w = (count_q != FULL_CNT);
    assign deq_valid_w = (count_q != '0);

    assign enq_fire = bus.enq_valid & enq_ready_w & ~flush;
    assign deq_fire = bus.deq_ready & deq_valid_w & ~flush;

    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (flush) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (enq_fire) wr_ptr_d = wr_ptr_q + 1'b1;
            if (deq_fire) rd_ptr_d = rd_ptr_q + 1'b1;
            case ({enq_fire, deq_fire})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
        end
        max_d = (count_d > max_q) ? count_d : max_q;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
            max_q    <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
            max_q    <= max_d;
        end
    end

    fetch_queue_storage #(
        .DEPTH (DEPTH),
        .WIDTH (XLEN + ILEN)
    ) u_storage (
        .clk     (clk),
        .rst     (rst),
        .we_i    (enq_fire),
        .waddr_i (wr_ptr_q),
        .wdata_i ({bus.enq_pc, bus.enq_instr}),
        .raddr_i (rd_ptr_q),
        .rdata_o (rd_data)
    );

    assign bus.enq_ready = enq_ready_w;
    assign bus.deq_valid = deq_valid_w;
    assign bus.deq_pc    = deq_valid_w ? rd_data[XLEN+ILEN-1:ILEN] : '0;
    assign bus.deq_instr = deq_valid_w ? rd_data[ILEN-1:0] : '0;
    assign count         = count_q;
    assign max_count     = max_q;

endmodule
